// File: rtl/config_loader.sv
// Configuration controller for the 3-column logic grid: loads a byte-wide bitstream
// into the grid configuration word, verifies an XOR checksum, then releases the grid.
module config_loader #(
    parameter int CONFIG_WIDTH = 1746,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    grid_nreset,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int NUM_BEATS = (CONFIG_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int CNT_W     = $clog2(NUM_BEATS + 1);
    // Number of meaningful bits carried by the final beat.
    localparam int LAST_W    = CONFIG_WIDTH - (NUM_BEATS - 1) * DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      beat_cnt;
    logic [DATA_WIDTH-1:0] checksum;
    logic                  handshake;

    assign handshake = in_valid && in_ready;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            config_out  <= '0;
            beat_cnt    <= '0;
            checksum    <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            grid_nreset <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state       <= LOAD;
                        config_out  <= '0;
                        beat_cnt    <= '0;
                        checksum    <= '0;
                        in_ready    <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        grid_nreset <= 1'b0;
                    end
                end

                LOAD: begin
                    if (abort) begin
                        state      <= IDLE;
                        config_out <= '0;
                        in_ready   <= 1'b0;
                        busy       <= 1'b0;
                    end else if (handshake) begin
                        // The final beat is truncated; its upper bits still feed the checksum.
                        if (beat_cnt == CNT_W'(NUM_BEATS - 1)) begin
                            config_out[CONFIG_WIDTH-1 -: LAST_W] <= in_data[LAST_W-1:0];
                            state <= CHECK;
                        end else begin
                            config_out[int'(beat_cnt) * DATA_WIDTH +: DATA_WIDTH] <= in_data;
                        end
                        checksum <= checksum ^ in_data;
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end

                CHECK: begin
                    if (abort) begin
                        state      <= IDLE;
                        config_out <= '0;
                        in_ready   <= 1'b0;
                        busy       <= 1'b0;
                    end else if (handshake) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == checksum) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            grid_nreset <= 1'b1;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                end

                default: begin
                    state       <= IDLE;
                    config_out  <= '0;
                    in_ready    <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    error       <= 1'b0;
                    grid_nreset <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: directed and randomized bitstream loads
// compared against a bit-level model of where each beat lands in the config word.
module tb_config_loader;

    localparam int CONFIG_WIDTH = 1746;
    localparam int DATA_WIDTH   = 8;
    localparam int NUM_BEATS    = 219;

    logic                    clock = 1'b0;
    logic                    nreset;
    logic                    start;
    logic                    abort;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [CONFIG_WIDTH-1:0] config_out;
    logic                    grid_nreset;
    logic                    busy;
    logic                    done;
    logic                    error;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int start_cyc;
    int accepted;

    logic [7:0]              beats [NUM_BEATS];
    logic [7:0]              good_sum;
    logic [7:0]              sum_byte;
    logic [CONFIG_WIDTH-1:0] exp_config;
    bit                      bad;

    config_loader #(
        .CONFIG_WIDTH(CONFIG_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) dut (
        .clock      (clock),
        .nreset     (nreset),
        .start      (start),
        .abort      (abort),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .config_out (config_out),
        .grid_nreset(grid_nreset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkConfig(input string tag, input logic [CONFIG_WIDTH-1:0] expected);
        logic [CONFIG_WIDTH-1:0] diff;
        diff = config_out ^ expected;
        n_checks++;
        assert (config_out === expected)
        else begin
            n_fails++;
            $error("[TB] FAIL %s: observed low %h expected low %h (%0d bits differ)",
                   tag, config_out[63:0], expected[63:0], $countones(diff));
        end
    endtask

    // kind 0: beat k = k[7:0]; kind 1: all 0xFF; kind 2: random bytes
    task automatic buildModel(input int kind);
        exp_config = '0;
        good_sum   = '0;
        for (int k = 0; k < NUM_BEATS; k++) begin
            case (kind)
                0:       beats[k] = 8'(k);
                1:       beats[k] = 8'hFF;
                default: beats[k] = 8'($urandom);
            endcase
            good_sum ^= beats[k];
            for (int b = 0; b < DATA_WIDTH; b++) begin
                if (k * DATA_WIDTH + b < CONFIG_WIDTH) exp_config[k * DATA_WIDTH + b] = beats[k][b];
            end
        end
    endtask

    task automatic applyStart();
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    // valid_mode 0: always valid, 1: every other cycle, 2: random
    task automatic applyStimulus(input logic [7:0] sum, input int valid_mode, input int gap_after,
                                 input int start_at, input int stop_after, output int count);
        int  idx;
        int  budget;
        bit  gap_done;
        bit  v;
        logic rdy;
        idx = 0;
        budget = 0;
        gap_done = 1'b0;
        while (idx < stop_after && budget < 3000) begin
            if (gap_after >= 0 && idx == gap_after + 1 && !gap_done) begin
                in_valid = 1'b0;
                repeat (10) tick();
                budget += 10;
                gap_done = 1'b1;
            end
            case (valid_mode)
                0:       v = 1'b1;
                1:       v = (budget % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            if (!v)                  in_data = 8'($urandom);
            else if (idx < NUM_BEATS) in_data = beats[idx];
            else                     in_data = sum;
            start = (idx == start_at) && v;
            rdy = in_ready;
            tick();
            start = 1'b0;
            budget++;
            if (v && rdy) idx++;
        end
        in_valid = 1'b0;
        count = idx;
        checkOutput("stream_accepted", 32'(idx), 32'(stop_after));
    endtask

    initial begin
        nreset   = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #2 nreset = 1'b0;
        #10;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_error", 32'(error), 32'd0);
        checkOutput("reset_grid_nreset", 32'(grid_nreset), 32'd0);
        checkConfig("reset_config", '0);
        @(negedge clock) nreset = 1'b1;
        in_valid = 1'b1;
        tick();
        checkOutput("idle_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Full counting-pattern load with valid held high
        buildModel(0);
        applyStart();
        checkOutput("load_in_ready", 32'(in_ready), 32'd1);
        checkOutput("load_busy", 32'(busy), 32'd1);
        applyStimulus(good_sum, 0, -1, -1, NUM_BEATS + 1, accepted);
        checkOutput("done_latency", 32'(cyc - start_cyc + 1), 32'd221);
        checkOutput("good_done", 32'(done), 32'd1);
        checkOutput("good_grid_nreset", 32'(grid_nreset), 32'd1);
        checkOutput("good_error", 32'(error), 32'd0);
        checkOutput("good_busy", 32'(busy), 32'd0);
        checkOutput("good_in_ready", 32'(in_ready), 32'd0);
        checkOutput("cfg_byte0", 32'(config_out[7:0]), 32'h00);
        checkOutput("cfg_byte1", 32'(config_out[15:8]), 32'h01);
        checkOutput("cfg_top2", 32'(config_out[1745:1744]), 32'h2);
        checkConfig("good_config", exp_config);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_in_done", 32'(done), 32'd1);

        // Reload from DONE with all-ones stream
        buildModel(1);
        applyStart();
        checkOutput("reload_grid_nreset_falls", 32'(grid_nreset), 32'd0);
        checkOutput("reload_done_clears", 32'(done), 32'd0);
        applyStimulus(8'hFF, 0, -1, -1, NUM_BEATS + 1, accepted);
        checkConfig("ones_config", '1);
        checkOutput("ones_done", 32'(done), 32'd1);

        // Corrupted checksum
        buildModel(0);
        applyStart();
        applyStimulus(good_sum ^ 8'h01, 0, -1, -1, NUM_BEATS + 1, accepted);
        checkOutput("bad_error", 32'(error), 32'd1);
        checkOutput("bad_done", 32'(done), 32'd0);
        checkOutput("bad_grid_nreset", 32'(grid_nreset), 32'd0);
        checkOutput("bad_in_ready", 32'(in_ready), 32'd0);
        checkConfig("bad_config_kept", exp_config);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start_beats_abort_busy", 32'(busy), 32'd1);
        checkOutput("start_beats_abort_error", 32'(error), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_load_busy", 32'(busy), 32'd0);

        // Toggling valid plus a 10-cycle gap after beat 100
        buildModel(0);
        applyStart();
        applyStimulus(good_sum, 1, 100, -1, NUM_BEATS + 1, accepted);
        checkConfig("toggle_config", exp_config);
        checkOutput("toggle_done", 32'(done), 32'd1);

        // Abort after beat 50; abort beats the concurrent handshake
        buildModel(2);
        applyStart();
        applyStimulus(good_sum, 0, -1, -1, 51, accepted);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = beats[51];
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_error", 32'(error), 32'd0);
        checkConfig("abort_config", '0);
        applyStart();
        applyStimulus(good_sum, 2, -1, 30, NUM_BEATS + 1, accepted);
        checkConfig("after_abort_config", exp_config);
        checkOutput("after_abort_done", 32'(done), 32'd1);

        // Asynchronous reset mid-load
        buildModel(2);
        applyStart();
        applyStimulus(good_sum, 2, -1, -1, 121, accepted);
        #2 nreset = 1'b0;
        #1;
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        checkOutput("midreset_grid_nreset", 32'(grid_nreset), 32'd0);
        checkConfig("midreset_config", '0);
        @(negedge clock) nreset = 1'b1;
        tick();
        checkOutput("post_reset_idle", 32'(busy), 32'd0);
        buildModel(2);
        applyStart();
        applyStimulus(good_sum, 2, -1, -1, NUM_BEATS + 1, accepted);
        checkConfig("post_reset_config", exp_config);
        checkOutput("post_reset_done", 32'(done), 32'd1);

        // Random streams with randomly corrupted checksums
        for (int r = 0; r < 3; r++) begin
            buildModel(2);
            bad = 1'($urandom_range(0, 1));
            sum_byte = bad ? (good_sum ^ (8'h01 << $urandom_range(0, 7))) : good_sum;
            applyStart();
            applyStimulus(sum_byte, 2, -1, -1, NUM_BEATS + 1, accepted);
            checkConfig("rand_config", exp_config);
            checkOutput("rand_done", 32'(done), 32'(!bad));
            checkOutput("rand_error", 32'(error), 32'(bad));
            checkOutput("rand_grid_nreset", 32'(grid_nreset), 32'(!bad));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
